// File: rtl/token_path_stepper.sv
// token_path_stepper: tracks each player's square, walks or teleports a token
// on request and emits serpentine-board screen coordinates for every step.
module token_path_stepper #(
    parameter int unsigned COLS        = 10,
    parameter int unsigned ROWS        = 10,
    parameter int unsigned ORIGIN_X    = 14,
    parameter int unsigned ORIGIN_Y    = 210,
    parameter int unsigned PITCH_X     = 30,
    parameter int unsigned PITCH_Y     = 22,
    parameter int unsigned HOME_X      = 5,
    parameter int unsigned PLAYER_DX   = 4,
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned STEP_TICKS  = 4,
    parameter int unsigned STEP_W      = 3,
    parameter int unsigned COORD_W     = 9,
    localparam int unsigned MAX_SQ     = COLS * ROWS,
    localparam int unsigned PL_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned SQ_W       = $clog2(MAX_SQ + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [PL_W-1:0]    move_player,
    input  logic               move_jump,
    input  logic [STEP_W-1:0]  move_steps,
    input  logic [SQ_W-1:0]    move_target,
    output logic               pos_valid,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [PL_W-1:0]    pos_player,
    output logic [SQ_W-1:0]    pos_square,
    output logic               done,
    output logic               rejected,
    output logic               win,
    input  logic [PL_W-1:0]    rd_player,
    output logic [SQ_W-1:0]    rd_square
);

    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned TICK_W = $clog2(STEP_TICKS + 1);
    localparam int unsigned SUM_W  = SQ_W + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WALK = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PL_W-1:0]   player_q, player_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [SQ_W-1:0]   target_q, target_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ROW_W-1:0]  conv_r_q, conv_r_d;
    logic [SQ_W-1:0]   conv_t_q, conv_t_d;
    logic              rej_q, rej_d;
    logic              ready_q;

    logic [SQ_W-1:0]   sq_q  [NUM_PLAYERS];
    logic [SQ_W-1:0]   sq_d  [NUM_PLAYERS];
    logic [ROW_W-1:0]  row_q [NUM_PLAYERS];
    logic [ROW_W-1:0]  row_d [NUM_PLAYERS];
    logic [COL_W-1:0]  col_q [NUM_PLAYERS];
    logic [COL_W-1:0]  col_d [NUM_PLAYERS];

    logic               pos_valid_q, pos_valid_d;
    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic [PL_W-1:0]    pos_player_q;
    logic [SQ_W-1:0]    pos_square_q;
    logic               done_q, done_d;
    logic               rejected_q, rejected_d;
    logic               win_q, win_d;

    logic [PL_W-1:0]   idx;
    logic [SQ_W-1:0]   cur_sq, nxt_sq;
    logic [ROW_W-1:0]  cur_row, nxt_row;
    logic [COL_W-1:0]  cur_col, nxt_col;
    logic [SQ_W-1:0]   emit_sq;
    logic [ROW_W-1:0]  emit_row;
    logic [COL_W-1:0]  emit_col;
    logic              emit_en;
    logic [TICK_W-1:0] tick_inc;
    logic [SUM_W-1:0]  walk_sum;
    logic [31:0]       cp_w, px_w, x_w, y_w;

    // The token being inspected: the requester while idle, the latched player otherwise.
    assign idx       = (state_q == S_IDLE) ? move_player : player_q;
    assign cur_sq    = sq_q[idx];
    assign cur_row   = row_q[idx];
    assign cur_col   = col_q[idx];
    assign tick_inc  = tick_q + TICK_W'(1);
    assign walk_sum  = SUM_W'(cur_sq) + SUM_W'(move_steps);
    assign rd_square = sq_q[rd_player];

    // Single-square advance along the serpentine board.
    always_comb begin
        nxt_sq  = cur_sq + SQ_W'(1);
        nxt_row = cur_row;
        nxt_col = cur_col + COL_W'(1);
        if (cur_sq == '0) begin
            nxt_row = '0;
            nxt_col = '0;
        end else if (cur_col == COL_W'(COLS - 1)) begin
            nxt_row = cur_row + ROW_W'(1);
            nxt_col = '0;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        rem_d       = rem_q;
        target_d    = target_q;
        tick_d      = tick_q;
        conv_r_d    = conv_r_q;
        conv_t_d    = conv_t_q;
        rej_d       = rej_q;
        sq_d        = sq_q;
        row_d       = row_q;
        col_d       = col_q;
        emit_en     = 1'b0;
        emit_sq     = cur_sq;
        emit_row    = cur_row;
        emit_col    = cur_col;
        pos_valid_d = 1'b0;
        done_d      = 1'b0;
        rejected_d  = 1'b0;
        win_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (move_valid && ready_q) begin
                    player_d = move_player;
                    rem_d    = move_steps;
                    target_d = move_target;
                    tick_d   = '0;
                    rej_d    = 1'b0;
                    if (!move_jump) begin
                        if ((move_steps == '0) || (walk_sum > SUM_W'(MAX_SQ))) begin
                            rej_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WALK;
                        end
                    end else if (move_target > SQ_W'(MAX_SQ)) begin
                        rej_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (move_target == '0) begin
                        sq_d[idx]  = '0;
                        row_d[idx] = '0;
                        col_d[idx] = '0;
                        state_d    = S_EMIT;
                    end else begin
                        conv_r_d = '0;
                        conv_t_d = move_target - SQ_W'(1);
                        state_d  = S_CONV;
                    end
                end
            end
            S_WALK: begin
                tick_d = tick_inc;
                if (tick_inc == TICK_W'(STEP_TICKS)) begin
                    tick_d         = '0;
                    sq_d[idx]      = nxt_sq;
                    row_d[idx]     = nxt_row;
                    col_d[idx]     = nxt_col;
                    emit_en        = 1'b1;
                    emit_sq        = nxt_sq;
                    emit_row       = nxt_row;
                    emit_col       = nxt_col;
                    pos_valid_d    = 1'b1;
                    rem_d          = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CONV: begin
                // Repeated subtraction replaces the divide by COLS.
                if (conv_t_q >= SQ_W'(COLS)) begin
                    conv_t_d = conv_t_q - SQ_W'(COLS);
                    conv_r_d = conv_r_q + ROW_W'(1);
                end else begin
                    sq_d[idx]  = target_q;
                    row_d[idx] = conv_r_q;
                    col_d[idx] = COL_W'(conv_t_q);
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                emit_en     = 1'b1;
                pos_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done_d     = 1'b1;
                rejected_d = rej_q;
                win_d      = (cur_sq == SQ_W'(MAX_SQ));
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Screen coordinates of the square being emitted; odd rows run right-to-left.
    always_comb begin
        cp_w = emit_row[0] ? (32'(COLS - 1) - 32'(emit_col)) : 32'(emit_col);
        px_w = 32'(PLAYER_DX) * 32'(player_q);
        if (emit_sq == '0) begin
            x_w = 32'(HOME_X) + px_w;
            y_w = 32'(ORIGIN_Y);
        end else begin
            x_w = 32'(ORIGIN_X) + 32'(PITCH_X) * cp_w + px_w;
            y_w = 32'(ORIGIN_Y) - 32'(PITCH_Y) * 32'(emit_row);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request context, token positions and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            player_q     <= '0;
            rem_q        <= '0;
            target_q     <= '0;
            tick_q       <= '0;
            conv_r_q     <= '0;
            conv_t_q     <= '0;
            rej_q        <= 1'b0;
            ready_q      <= 1'b1;
            for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                sq_q[i]  <= '0;
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
            pos_valid_q  <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            pos_player_q <= '0;
            pos_square_q <= '0;
            done_q       <= 1'b0;
            rejected_q   <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            player_q     <= player_d;
            rem_q        <= rem_d;
            target_q     <= target_d;
            tick_q       <= tick_d;
            conv_r_q     <= conv_r_d;
            conv_t_q     <= conv_t_d;
            rej_q        <= rej_d;
            ready_q      <= (state_d == S_IDLE);
            sq_q         <= sq_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pos_valid_q  <= pos_valid_d;
            if (emit_en) begin
                pos_x_q      <= COORD_W'(x_w);
                pos_y_q      <= COORD_W'(y_w);
                pos_player_q <= player_q;
                pos_square_q <= emit_sq;
            end
            done_q       <= done_d;
            rejected_q   <= rejected_d;
            win_q        <= win_d;
        end
    end

    assign move_ready = ready_q;
    assign pos_valid  = pos_valid_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign pos_player = pos_player_q;
    assign pos_square = pos_square_q;
    assign done       = done_q;
    assign rejected   = rejected_q;
    assign win        = win_q;

endmodule

// File: tb/tb_token_path_stepper.sv
// Directed bench for token_path_stepper with default parameters.
module tb_token_path_stepper;

    localparam int unsigned PL_W    = 1;
    localparam int unsigned SQ_W    = 7;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned COORD_W = 9;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic               move_valid = 1'b0;
    logic               move_ready;
    logic [PL_W-1:0]    move_player = '0;
    logic               move_jump = 1'b0;
    logic [STEP_W-1:0]  move_steps = '0;
    logic [SQ_W-1:0]    move_target = '0;
    logic               pos_valid;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [PL_W-1:0]    pos_player;
    logic [SQ_W-1:0]    pos_square;
    logic               done;
    logic               rejected;
    logic               win;
    logic [PL_W-1:0]    rd_player = '0;
    logic [SQ_W-1:0]    rd_square;

    token_path_stepper dut (
        .clock       (clock),
        .resetn      (resetn),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_player (move_player),
        .move_jump   (move_jump),
        .move_steps  (move_steps),
        .move_target (move_target),
        .pos_valid   (pos_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_player  (pos_player),
        .pos_square  (pos_square),
        .done        (done),
        .rejected    (rejected),
        .win         (win),
        .rd_player   (rd_player),
        .rd_square   (rd_square)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    int ev_k[$];
    int ev_x[$];
    int ev_y[$];
    int ev_sq[$];
    int ev_pl[$];
    int done_k;
    int done_rej;
    int done_win;
    int ready_k1;

    // Count one comparison and report it when it misses.
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present a request at the falling edge; the next rising edge accepts it.
    task automatic send(input int p, input int j, input int steps, input int target);
        @(negedge clock);
        move_player = PL_W'(p);
        move_jump   = j[0];
        move_steps  = STEP_W'(steps);
        move_target = SQ_W'(target);
        move_valid  = 1'b1;
        @(posedge clock);
        #1;
        move_valid = 1'b0;
    endtask

    // Record pulses k cycles after the accept edge until done or the budget expires.
    task automatic collect(input int max_cyc);
        ev_k.delete(); ev_x.delete(); ev_y.delete(); ev_sq.delete(); ev_pl.delete();
        done_k = -1; done_rej = -1; done_win = -1; ready_k1 = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) ready_k1 = int'(move_ready);
            if (pos_valid) begin
                ev_k.push_back(k);
                ev_x.push_back(int'(pos_x));
                ev_y.push_back(int'(pos_y));
                ev_sq.push_back(int'(pos_square));
                ev_pl.push_back(int'(pos_player));
            end
            if (done) begin
                done_k   = k;
                done_rej = int'(rejected);
                done_win = int'(win);
                break;
            end
        end
    endtask

    task automatic exp_pos(input int i, input int k, input int x, input int y,
                           input int sq, input int pl);
        if (i < ev_k.size()) begin
            check($sformatf("pos%0d_cycle", i), ev_k[i], k);
            check($sformatf("pos%0d_x", i), ev_x[i], x);
            check($sformatf("pos%0d_y", i), ev_y[i], y);
            check($sformatf("pos%0d_square", i), ev_sq[i], sq);
            check($sformatf("pos%0d_player", i), ev_pl[i], pl);
        end else begin
            check($sformatf("pos%0d_present", i), ev_k.size(), i + 1);
        end
    endtask

    task automatic exp_done(input int k, input int rej, input int w, input int npos);
        check("done_cycle", done_k, k);
        check("rejected", done_rej, rej);
        check("win", done_win, w);
        check("pos_count", ev_k.size(), npos);
    endtask

    task automatic exp_rd(input int p, input int sq);
        @(negedge clock);
        rd_player = PL_W'(p);
        #1;
        check($sformatf("rd_square_p%0d", p), int'(rd_square), sq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npos;
        int got_done;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_ready", int'(move_ready), 1);
        check("rst_pos_valid", int'(pos_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_pos_x", int'(pos_x), 0);
        check("rst_pos_y", int'(pos_y), 0);
        check("rst_pos_square", int'(pos_square), 0);
        resetn = 1'b1;
        exp_rd(0, 0);
        exp_rd(1, 0);

        // p0 walks 3 from home
        send(0, 0, 3, 0);
        collect(20);
        exp_pos(0, 4, 14, 210, 1, 0);
        exp_pos(1, 8, 44, 210, 2, 0);
        exp_pos(2, 12, 74, 210, 3, 0);
        exp_done(13, 0, 0, 3);
        check("ready_busy", ready_k1, 0);
        check("ready_after_done", int'(move_ready), 1);
        check("pos_x_hold", int'(pos_x), 74);
        exp_rd(0, 3);
        exp_rd(1, 0);

        // p0 jump to 9 (row 0), then walk over the row turn
        send(0, 1, 0, 9);
        collect(20);
        exp_pos(0, 2, 254, 210, 9, 0);
        exp_done(3, 0, 0, 1);
        send(0, 0, 3, 0);
        collect(20);
        exp_pos(0, 4, 284, 210, 10, 0);
        exp_pos(1, 8, 284, 188, 11, 0);
        exp_pos(2, 12, 254, 188, 12, 0);
        exp_done(13, 0, 0, 3);

        // p1 ladder to 100: nine subtraction passes
        send(1, 1, 0, 100);
        collect(30);
        exp_pos(0, 11, 18, 12, 100, 1);
        exp_done(12, 0, 1, 1);
        exp_rd(1, 100);

        // p0 to 97, overshooting walk rejected, exact walk wins
        send(0, 1, 0, 97);
        collect(30);
        exp_pos(0, 11, 104, 12, 97, 0);
        exp_done(12, 0, 0, 1);
        send(0, 0, 4, 0);
        collect(20);
        exp_done(1, 1, 0, 0);
        exp_rd(0, 97);
        send(0, 0, 3, 0);
        collect(20);
        exp_pos(0, 4, 74, 12, 98, 0);
        exp_pos(1, 8, 44, 12, 99, 0);
        exp_pos(2, 12, 14, 12, 100, 0);
        exp_done(13, 0, 1, 3);

        // Walk from the last square and out-of-range jump are rejected
        send(0, 0, 1, 0);
        collect(20);
        check("max_walk_done_cycle", done_k, 1);
        check("max_walk_rejected", done_rej, 1);
        check("max_walk_pos_count", ev_k.size(), 0);
        send(0, 1, 0, 101);
        collect(20);
        check("bad_jump_done_cycle", done_k, 1);
        check("bad_jump_rejected", done_rej, 1);
        check("bad_jump_pos_count", ev_k.size(), 0);
        exp_rd(0, 100);

        // p0 jumps home from the last square, then a zero-step walk is rejected
        send(0, 1, 0, 0);
        collect(20);
        exp_pos(0, 1, 5, 210, 0, 0);
        exp_done(2, 0, 0, 1);
        send(0, 0, 0, 0);
        collect(20);
        exp_done(1, 1, 0, 0);

        // move_valid held through a walk, back-to-back request after done
        @(negedge clock);
        move_player = 1'b0;
        move_jump   = 1'b0;
        move_steps  = 3'd2;
        move_valid  = 1'b1;
        npos = 0;
        got_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            #1;
            if (pos_valid) npos++;
            if (done) begin
                got_done = 1;
                break;
            end
        end
        check("hold_done_seen", got_done, 1);
        check("hold_pos_count", npos, 2);
        move_player = 1'b1;
        move_jump   = 1'b1;
        move_target = '0;
        @(posedge clock);
        #1;
        move_valid = 1'b0;
        collect(10);
        exp_pos(0, 1, 9, 210, 0, 1);
        exp_done(2, 0, 0, 1);
        exp_rd(0, 2);
        exp_rd(1, 0);

        // Reset in the middle of a walk aborts it
        send(0, 0, 3, 0);
        repeat (6) @(posedge clock);
        #1;
        resetn = 1'b0;
        #2;
        check("midrst_ready", int'(move_ready), 1);
        check("midrst_pos_valid", int'(pos_valid), 0);
        rd_player = 1'b0;
        #1;
        check("midrst_rd_p0", int'(rd_square), 0);
        @(negedge clock);
        resetn = 1'b1;
        npos = 0;
        got_done = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clock);
            #1;
            if (pos_valid) npos++;
            if (done) got_done++;
        end
        check("midrst_no_pos", npos, 0);
        check("midrst_no_done", got_done, 0);
        check("midrst_ready_after", int'(move_ready), 1);
        exp_rd(0, 0);
        exp_rd(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/token_path_stepper.md
# token_path_stepper

Parametrised successor to the fixed 100-square coordinate table. It holds the current square of every player token. On request it walks a token one square at a time, or teleports it for a snake or ladder. At each step it emits the token's screen coordinates, computed arithmetically for a serpentine board of any size with a per-player offset. It sits between the game-rules FSM and the VGA token-drawing logic.

## Interface
Parameters:
- COLS, 10, squares per board row
- ROWS, 10, board rows; MAX_SQ = COLS*ROWS
- ORIGIN_X, 14, x of square 1
- ORIGIN_Y, 210, y of row 0
- PITCH_X, 30, horizontal cell pitch
- PITCH_Y, 22, vertical cell pitch
- HOME_X, 5, x of square 0 (off-board start)
- PLAYER_DX, 4, x offset added per player index
- NUM_PLAYERS, 2, token count; PL_W = max(1, clog2(NUM_PLAYERS))
- STEP_TICKS, 4, cycles per walked square (≥1)
- STEP_W, 3, width of step count
- COORD_W, 9, coordinate width; SQ_W = clog2(MAX_SQ+1)

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- move_valid  in  1  request strobe
- move_ready  out  1  high only in IDLE
- move_player  in  PL_W  token index
- move_jump  in  1  1 = teleport to move_target; 0 = walk move_steps
- move_steps  in  STEP_W  squares to walk
- move_target  in  SQ_W  jump destination
- pos_valid  out  1  one-cycle pulse per emitted position
- pos_x, pos_y  out  COORD_W  coordinates
- pos_player  out  PL_W  player of the emitted position
- pos_square  out  SQ_W  square of the emitted position
- done  out  1  one-cycle pulse ending a request
- rejected  out  1  valid with done; request caused no movement
- win  out  1  valid with done; final square == MAX_SQ
- rd_player  in  PL_W  combinational query index
- rd_square  out  SQ_W  current square of rd_player

## Operation
- Per-player state: square, row (0..ROWS-1), col (0..COLS-1). Row and col are derived for square ≥1 as (sq-1)/COLS and (sq-1)%COLS.
- States:
  - IDLE: on accept (move_valid & move_ready), latch the request.
  - If walking with steps==0, or square+steps > MAX_SQ: go to DONE with rejected=1.
  - If walking otherwise: go to WALK.
  - If jumping with target > MAX_SQ: go to DONE with rejected=1.
  - If jumping to target 0: go to EMIT.
  - If jumping otherwise: go to CONV.
- WALK: tick counter counts 1..STEP_TICKS. At STEP_TICKS, advance the square by 1:
  - from square 0: row=0, col=0.
  - col==COLS-1: row+1, col=0.
  - otherwise: col+1.
  - Emit pos_valid. Repeat until remaining steps reach 0, then go to DONE.
- CONV: with r=0 and t=target-1, each cycle t≥COLS gives t-=COLS and r+=1. When t<COLS, set row=r, col=t, square=target, then go to EMIT. No divider or multiplier on the path.
- EMIT: one pos_valid, then DONE.
- DONE: pulse done, with win = (square==MAX_SQ), then return to IDLE.
- Coordinates:
  - sq==0: x = HOME_X + p*PLAYER_DX, y = ORIGIN_Y.
  - else: cp = row even ? col : COLS-1-col; x = ORIGIN_X + PITCH_X*cp + p*PLAYER_DX; y = ORIGIN_Y - PITCH_Y*row.
  - All multiplies are by constants or small indices. Results are truncated to COORD_W; overflow is the integrator's problem.
- A token at MAX_SQ rejects any walk of 1 or more steps. A jump from MAX_SQ is allowed.
- Requests to other players are independent. Only one request is in flight at a time.

## Timing
- Reset (async assert, sync release): IDLE, move_ready=1, all squares/rows/cols 0, pos_valid=done=rejected=win=0, pos_x=pos_y=pos_square=pos_player=0, tick counter 0.
- Reset asserted mid-request aborts it: no done, all tokens return to 0.
- Accept at edge A. Walk of n squares: pos_valid at A+k*STEP_TICKS for k=1..n, done at A+n*STEP_TICKS+1.
- Rejected: done at A+1, no pos_valid.
- Jump to target T≥1 with row R: done at A+R+3. Jump to T=0: done at A+2.
- pos_x, pos_y, pos_square, pos_player are registered and hold their value between pulses.
- move_ready=0 from A+1 until the cycle after done. move_valid while not ready is ignored.
- rd_square reflects updates the cycle after they are registered.

## Test plan
- Reset, then p0 walk 3, STEP_TICKS=4, accept at cycle 0 → pos (14,210),(44,210),(74,210) for squares 1,2,3 at cycles 4,8,12; done at 13 with rejected=0, win=0; rd_square=3.
- p0 at 9, walk 3 → square 10 (284,210), 11 (284,188), 12 (254,188).
- p1 jump to 100 → after 9 CONV iterations, pos (18,12), square 100; done with win=1.
- p0 at 97, walk 4 → done at A+1 with rejected=1, no pos_valid, rd_square=97. Same request with walk 3 → ends at 100 with win=1.
- move_valid held high throughout a walk → exactly one accept. A second request (p1 jump 0) is accepted the cycle after done and emits (9,210).
- resetn pulsed low at cycle 6 of a walk → next pos_valid never fires; move_ready=1; rd_square=0 for both players.
